// File: rtl/dmc_dma_pkg.sv
// dmc_dma_pkg: shared state encoding and sizing constants for the DMC sample-fetch DMA engine.
package dmc_dma_pkg;
   localparam int STATE_W = 3;
   localparam int STALL_CNT_W = 2;
   localparam int TIMEOUT_CYCLES_DEF = 255;
   typedef enum logic [STATE_W-1:0] {IDLE, WAIT_RD, HALT, FETCH, COOL} state_t;
endpackage

// File: rtl/dmc_dma_watchdog.sv
// dmc_dma_watchdog: counts clocks while a fetch is outstanding and flags expiry on the last one.
module dmc_dma_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else cnt <= run ? cnt + 1'b1 : '0;
   assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/dmc_dma_engine.sv
// dmc_dma_engine: halts the CPU on a read cycle, steals STALL_CYCLES cycles and fetches one DMC byte.
// Define DMC_DMA_TIMEOUT_EN to add the FETCH watchdog, TIMEOUT_CYCLES and a sticky oErr.
module dmc_dma_engine
   import dmc_dma_pkg::*;
#(
   parameter int STALL_CYCLES = 4,
   parameter int ADDR_WIDTH = 16
`ifdef DMC_DMA_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iDMA_req,
   input  logic [ADDR_WIDTH-1:0] iDMA_addr,
   output logic                  oDMA_ack,
   output logic [7:0]            oDMA_data,
   input  logic                  iCpu_cycle,
   input  logic                  iCpu_rw,
   output logic                  oCpu_rdy,
   output logic [ADDR_WIDTH-1:0] oMem_addr,
   output logic                  oMem_rd,
   input  logic [7:0]            iMem_data,
   input  logic                  iMem_valid,
   output logic                  oErr
);
   state_t state;
   logic [STALL_CNT_W-1:0] cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic expired;
`ifdef DMC_DMA_TIMEOUT_EN
   dmc_dma_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk(iClk), .rst_n(iReset_n), .run(state == FETCH), .expired(expired)
   );
   always_ff @(posedge iClk)
      if (!iReset_n) oErr <= 1'b0;
      else if (state == FETCH && expired && !iMem_valid) oErr <= 1'b1;
`else
   assign expired = 1'b0;
   assign oErr = 1'b0;
`endif
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state     <= IDLE;
         oCpu_rdy  <= 1'b1;
         oDMA_ack  <= 1'b0;
         oDMA_data <= 8'h00;
         oMem_rd   <= 1'b0;
         oMem_addr <= '0;
         cnt       <= '0;
         addr_q    <= '0;
      end else begin
         oDMA_ack <= 1'b0;
         case (state)
            IDLE:
               if (iDMA_req) begin
                  addr_q <= iDMA_addr;
                  state  <= WAIT_RD;
               end
            WAIT_RD:
               if (!iDMA_req) begin
                  oCpu_rdy <= 1'b1;
                  state    <= IDLE;
               end else if (iCpu_cycle && iCpu_rw) begin
                  oCpu_rdy <= 1'b0;
                  cnt      <= STALL_CNT_W'(1);
                  if (STALL_CYCLES == 1) begin
                     oMem_addr <= addr_q;
                     oMem_rd   <= 1'b1;
                     state     <= FETCH;
                  end else state <= HALT;
               end
            HALT:
               if (!iDMA_req) begin
                  oCpu_rdy <= 1'b1;
                  state    <= IDLE;
               end else if (iCpu_cycle) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == STALL_CNT_W'(STALL_CYCLES - 1)) begin
                     oMem_addr <= addr_q;
                     oMem_rd   <= 1'b1;
                     state     <= FETCH;
                  end
               end
            FETCH:
               // A request withdrawn mid-fetch still finishes the bus cycle but is not acknowledged.
               if (iMem_valid || expired) begin
                  oMem_rd  <= 1'b0;
                  oCpu_rdy <= 1'b1;
                  state    <= COOL;
                  if (iDMA_req) begin
                     oDMA_ack  <= 1'b1;
                     oDMA_data <= iMem_valid ? iMem_data : 8'h00;
                  end
               end
            COOL:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmc_dma_engine.sv
// tb_dmc_dma_engine: vector table for the basic fetch/write-skip flows plus directed abort, re-issue, reset and timeout sequences.
module tb_dmc_dma_engine;
   logic iClk = 1'b0, iReset_n = 1'b0, iDMA_req = 1'b0, iCpu_cycle = 1'b0, iCpu_rw = 1'b1, iMem_valid = 1'b0;
   logic [15:0] iDMA_addr = '0;
   logic [7:0] iMem_data = '0;
   logic oDMA_ack, oCpu_rdy, oMem_rd, oErr;
   logic [7:0] oDMA_data;
   logic [15:0] oMem_addr;
   int errors = 0, checks = 0, ack_cnt = 0, rd_cnt = 0;
   logic prev_ack = 1'b0, prev_rd = 1'b0;

   typedef struct {
      logic req; logic [15:0] addr; logic cyc; logic rw; logic mval; logic [7:0] mdata;
      logic rdy; logic ack; logic [7:0] data; logic rd; logic [15:0] maddr;
   } vec_t;
   vec_t tbl [20];

   always #5 iClk = ~iClk;

   dmc_dma_engine #(.STALL_CYCLES(4), .ADDR_WIDTH(16)
`ifdef DMC_DMA_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iDMA_req(iDMA_req), .iDMA_addr(iDMA_addr),
      .oDMA_ack(oDMA_ack), .oDMA_data(oDMA_data), .iCpu_cycle(iCpu_cycle), .iCpu_rw(iCpu_rw),
      .oCpu_rdy(oCpu_rdy), .oMem_addr(oMem_addr), .oMem_rd(oMem_rd), .iMem_data(iMem_data),
      .iMem_valid(iMem_valid), .oErr(oErr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic drive(input logic req, input logic [15:0] addr, input logic cyc, input logic rw,
                        input logic mval, input logic [7:0] mdata);
      iDMA_req = req; iDMA_addr = addr; iCpu_cycle = cyc; iCpu_rw = rw; iMem_valid = mval; iMem_data = mdata;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rdy"}, 32'(oCpu_rdy), 32'd1);
      check({tag, "_ack"}, 32'(oDMA_ack), 32'd0);
      check({tag, "_data"}, 32'(oDMA_data), 32'h00);
      check({tag, "_rd"}, 32'(oMem_rd), 32'd0);
      check({tag, "_addr"}, 32'(oMem_addr), 32'h0000);
      check({tag, "_err"}, 32'(oErr), 32'd0);
   endtask

   // Bus-level monitor: counts acks and read strobes, and rejects back-to-back acks.
   always @(negedge iClk) begin
      if (oDMA_ack) begin
         ack_cnt <= ack_cnt + 1;
         check("ack_spacing", 32'(prev_ack), 32'd0);
      end
      if (oMem_rd && !prev_rd) rd_cnt <= rd_cnt + 1;
      prev_ack <= oDMA_ack;
      prev_rd <= oMem_rd;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int pulses, a0, r0;
      tbl[0]  = '{1'b1, 16'hC040, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      tbl[3]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
      tbl[4]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 16'hC040};
      tbl[5]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 16'hC040};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[8]  = '{1'b1, 16'h8001, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[9]  = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[10] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[11] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[12] = '{1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[13] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[14] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[15] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 16'hC040};
      tbl[16] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 16'h8001};
      tbl[17] = '{1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 16'h8001};
      tbl[18] = '{1'b1, 16'h8001, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 16'h8001};
      tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0, 16'h8001};

      step(); step();
      check_reset("reset");
      iReset_n = 1'b1;

      // T1 fetch and T2 write-cycle skipping, one table row per clock.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 8 && tbl[i].cyc && !oCpu_rdy) pulses++;
         drive(tbl[i].req, tbl[i].addr, tbl[i].cyc, tbl[i].rw, tbl[i].mval, tbl[i].mdata);
         step();
         check($sformatf("vec%0d_rdy", i), 32'(oCpu_rdy), 32'(tbl[i].rdy));
         check($sformatf("vec%0d_ack", i), 32'(oDMA_ack), 32'(tbl[i].ack));
         check($sformatf("vec%0d_data", i), 32'(oDMA_data), 32'(tbl[i].data));
         check($sformatf("vec%0d_rd", i), 32'(oMem_rd), 32'(tbl[i].rd));
         check($sformatf("vec%0d_maddr", i), 32'(oMem_addr), 32'(tbl[i].maddr));
         if (i == 7) check("t1_halt_pulses", 32'(pulses), 32'd4);
      end
      check("t1t2_ack_count", 32'(ack_cnt), 32'd2);

      // T3 abort in HALT after two stall pulses.
      a0 = ack_cnt; r0 = rd_cnt;
      drive(1'b1, 16'h4000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      drive(1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 8'h00); step(); step(); step();
      check("t3_halted", 32'(oCpu_rdy), 32'd0);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      check("t3_release", 32'(oCpu_rdy), 32'd1);
      drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00); step(); step(); step();
      check("t3_still_run", 32'(oCpu_rdy), 32'd1);
      check("t3_no_rd", 32'(rd_cnt - r0), 32'd0);
      check("t3_no_ack", 32'(ack_cnt - a0), 32'd0);

      // T4 request held past ack: no halt within two clocks, single ack.
      a0 = ack_cnt;
      drive(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 8'h00); step();
      drive(1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 8'h00); step(); step(); step(); step();
      check("t4_rd", 32'(oMem_rd), 32'd1);
      check("t4_maddr", 32'(oMem_addr), 32'h2222);
      drive(1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 8'h5A); step();
      check("t4_ack", 32'(oDMA_ack), 32'd1);
      check("t4_data", 32'(oDMA_data), 32'h5A);
      drive(1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 8'h00); step();
      check("t4_p1_ack", 32'(oDMA_ack), 32'd0);
      check("t4_p1_rdy", 32'(oCpu_rdy), 32'd1);
      step();
      check("t4_p2_ack", 32'(oDMA_ack), 32'd0);
      check("t4_p2_rdy", 32'(oCpu_rdy), 32'd1);
      step();
      check("t4_reissue_rdy", 32'(oCpu_rdy), 32'd0);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      check("t4_abort_rdy", 32'(oCpu_rdy), 32'd1);
      step();
      check("t4_one_ack", 32'(ack_cnt - a0), 32'd1);

`ifdef DMC_DMA_TIMEOUT_EN
      // T6 memory never answers: watchdog completes the fetch on FETCH clock 8.
      drive(1'b1, 16'h6000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      drive(1'b1, 16'h6000, 1'b1, 1'b1, 1'b0, 8'h00); step(); step(); step(); step();
      drive(1'b1, 16'h6000, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 1; k < 8; k++) begin
         step();
         check($sformatf("t6_wait%0d_ack", k), 32'(oDMA_ack), 32'd0);
         check($sformatf("t6_wait%0d_rd", k), 32'(oMem_rd), 32'd1);
      end
      step();
      check("t6_ack", 32'(oDMA_ack), 32'd1);
      check("t6_data", 32'(oDMA_data), 32'h00);
      check("t6_err", 32'(oErr), 32'd1);
      check("t6_rdy", 32'(oCpu_rdy), 32'd1);
      check("t6_rd", 32'(oMem_rd), 32'd0);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00); step(); step(); step();
      check("t6_err_sticky", 32'(oErr), 32'd1);
`else
      check("err_tied", 32'(oErr), 32'd0);
`endif

      // T5 reset during FETCH, then a late iMem_valid.
      drive(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 8'h00); step();
      drive(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 8'h00); step(); step(); step(); step();
      check("t5_rd", 32'(oMem_rd), 32'd1);
      check("t5_maddr", 32'(oMem_addr), 32'h5555);
      check("t5_rdy", 32'(oCpu_rdy), 32'd0);
      iReset_n = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      check_reset("t5_reset");
      iReset_n = 1'b1;
      a0 = ack_cnt;
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h99); step();
      check("t5_late_ack", 32'(oDMA_ack), 32'd0);
      check("t5_late_data", 32'(oDMA_data), 32'h00);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00); step();
      check("t5_rd_idle", 32'(oMem_rd), 32'd0);
      check("t5_rdy_idle", 32'(oCpu_rdy), 32'd1);
      check("t5_no_ack", 32'(ack_cnt - a0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
